// File: rtl/mnist_class_vote_argmax.sv
// Two-stage vote popcount + argmax classifier with optional accuracy statistics.
// Define MNIST_CLASS_VOTE_STATS_EN to compile in the stat_total/stat_ok/stat_done counters.
module mnist_class_vote_argmax #(
    parameter int USER_WIDTH  = 8,
    parameter int CLASS_NUM   = 10,
    parameter int CHANNEL_NUM = 7,
    parameter int COUNT_WIDTH = 3,
    parameter int INDEX_WIDTH = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             cke,
    input  logic [CLASS_NUM*CHANNEL_NUM-1:0] in_data,
    input  logic [USER_WIDTH-1:0]            in_user,
    input  logic                             in_last,
    input  logic                             in_valid,
    output logic [INDEX_WIDTH-1:0]           out_class,
    output logic [COUNT_WIDTH-1:0]           out_count,
    output logic                             out_tie,
    output logic                             out_none,
    output logic [USER_WIDTH-1:0]            out_user,
    output logic                             out_last,
    output logic                             out_valid,
    output logic [31:0]                      stat_total,
    output logic [31:0]                      stat_ok,
    output logic                             stat_done
);

    logic [CLASS_NUM-1:0][COUNT_WIDTH-1:0] cnt_d, cnt_q;
    logic [USER_WIDTH-1:0]                 user1_q, out_user_q;
    logic                                  last1_q, out_last_q;
    logic [2:1]                            vld_pipe_q;
    logic [INDEX_WIDTH-1:0]                idx_d, out_class_q;
    logic [COUNT_WIDTH-1:0]                best_d, out_count_q;
    logic                                  tie_d, none_d, out_tie_q, out_none_q;

    // Channel j of class i sits at j*CLASS_NUM+i, so classes interleave across channels.
    always_comb begin
        for (int i = 0; i < CLASS_NUM; i++) begin
            cnt_d[i] = '0;
            for (int j = 0; j < CHANNEL_NUM; j++)
                cnt_d[i] = cnt_d[i] + COUNT_WIDTH'(in_data[j*CLASS_NUM+i]);
        end
    end

    // Strict '>' keeps the lowest index on ties; an all-zero vector leaves idx at 0.
    always_comb begin
        best_d = '0;
        idx_d  = '0;
        for (int i = 0; i < CLASS_NUM; i++) begin
            if (cnt_q[i] > best_d) begin
                best_d = cnt_q[i];
                idx_d  = INDEX_WIDTH'(i);
            end
        end
        tie_d = 1'b0;
        for (int i = 0; i < CLASS_NUM; i++) begin
            if (cnt_q[i] == best_d && INDEX_WIDTH'(i) != idx_d && best_d != '0)
                tie_d = 1'b1;
        end
        none_d = (best_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe_q  <= '0;
            cnt_q       <= '0;
            user1_q     <= '0;
            last1_q     <= 1'b0;
            out_class_q <= '0;
            out_count_q <= '0;
            out_tie_q   <= 1'b0;
            out_none_q  <= 1'b0;
            out_user_q  <= '0;
            out_last_q  <= 1'b0;
        end else if (cke) begin
            vld_pipe_q  <= {vld_pipe_q[1], in_valid};
            cnt_q       <= cnt_d;
            user1_q     <= in_user;
            last1_q     <= in_last;
            out_class_q <= idx_d;
            out_count_q <= best_d;
            out_tie_q   <= tie_d;
            out_none_q  <= none_d;
            out_user_q  <= user1_q;
            out_last_q  <= last1_q;
        end
    end

    assign out_class = out_class_q;
    assign out_count = out_count_q;
    assign out_tie   = out_tie_q;
    assign out_none  = out_none_q;
    assign out_user  = out_user_q;
    assign out_last  = out_last_q;
    assign out_valid = vld_pipe_q[2];

`ifdef MNIST_CLASS_VOTE_STATS_EN
    logic [31:0] total_d, total_q, ok_d, ok_q;
    logic        done_d, done_q, correct;

    // A sample is counted on the cke edge that retires it from the output stage.
    always_comb begin
        correct = vld_pipe_q[2] && !out_none_q &&
                  (out_class_q == out_user_q[INDEX_WIDTH-1:0]);
        total_d = total_q;
        ok_d    = ok_q;
        done_d  = done_q;
        if (vld_pipe_q[2] && !done_q) begin
            if (total_q != '1) total_d = total_q + 32'd1;
            if (correct && ok_q != '1) ok_d = ok_q + 32'd1;
            if (out_last_q) done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            total_q <= '0;
            ok_q    <= '0;
            done_q  <= 1'b0;
        end else if (cke) begin
            total_q <= total_d;
            ok_q    <= ok_d;
            done_q  <= done_d;
        end
    end

    assign stat_total = total_q;
    assign stat_ok    = ok_q;
    assign stat_done  = done_q;
`else
    assign stat_total = '0;
    assign stat_ok    = '0;
    assign stat_done  = 1'b0;
`endif

endmodule

// File: tb/tb_mnist_class_vote_argmax.sv
// Scoreboard bench: driver pushes expected results, monitor pops on each cke edge and checks latency.
module tb_mnist_class_vote_argmax;
    localparam int UW = 8, CN = 10, CH = 7, CW = 3, IW = 4, DW = CN*CH;
`ifdef MNIST_CLASS_VOTE_STATS_EN
    localparam bit ST = 1'b1;
`else
    localparam bit ST = 1'b0;
`endif

    logic          clk = 1'b0, reset = 1'b1, cke = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [UW-1:0] in_user = '0;
    logic          in_last = 1'b0, in_valid = 1'b0;
    logic [IW-1:0] out_class;
    logic [CW-1:0] out_count;
    logic          out_tie, out_none, out_last, out_valid, stat_done;
    logic [UW-1:0] out_user;
    logic [31:0]   stat_total, stat_ok;

    mnist_class_vote_argmax #(.USER_WIDTH(UW), .CLASS_NUM(CN), .CHANNEL_NUM(CH),
                              .COUNT_WIDTH(CW), .INDEX_WIDTH(IW)) dut (
        .clk(clk), .reset(reset), .cke(cke), .in_data(in_data), .in_user(in_user),
        .in_last(in_last), .in_valid(in_valid), .out_class(out_class), .out_count(out_count),
        .out_tie(out_tie), .out_none(out_none), .out_user(out_user), .out_last(out_last),
        .out_valid(out_valid), .stat_total(stat_total), .stat_ok(stat_ok), .stat_done(stat_done));

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] cls;
        logic [CW-1:0] cnt;
        logic          tie, none, last;
        logic [UW-1:0] user;
        int            tag;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0, n_bad = 0;
    int   drv_edges = 0, mon_edges = 0;
    int   exp_total = 0, exp_ok = 0;
    bit   exp_done = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: on every qualifying edge, the head entry is due exactly one cke edge after acceptance.
    bit           mon_adv, mon_rst;
    exp_t         mon_e;
    logic [127:0] mon_prev = '0, mon_now;
    always @(posedge clk) begin
        mon_adv = cke && !reset;
        mon_rst = reset;
        #1;
        mon_now = {stat_total, stat_ok, stat_done, out_valid, out_class, out_count,
                   out_tie, out_none, out_user, out_last};
        if (mon_adv) begin
            mon_edges++;
            if (sb.size() > 0 && sb[0].tag + 1 == mon_edges) begin
                mon_e = sb.pop_front();
                check("out_valid", 128'(out_valid), 128'(1'b1));
                check("outputs", 128'({out_class, out_count, out_tie, out_none, out_user, out_last}),
                      128'({mon_e.cls, mon_e.cnt, mon_e.tie, mon_e.none, mon_e.user, mon_e.last}));
            end else begin
                check("spurious_valid", 128'(out_valid), 128'(1'b0));
            end
        end else if (!mon_rst) begin
            check("hold_on_cke_low", mon_now, mon_prev);
        end
        mon_prev = mon_now;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] votes(input int cls, input int n);
        logic [DW-1:0] r = '0;
        for (int j = 0; j < n; j++) r[j*CN+cls] = 1'b1;
        return r;
    endfunction

    task automatic model(input logic [DW-1:0] d, output logic [IW-1:0] cls,
                         output logic [CW-1:0] cnt, output logic tie, output logic none);
        int c[CN];
        int mx = 0, eq = 0;
        bit found = 1'b0;
        for (int i = 0; i < CN; i++) begin
            c[i] = 0;
            for (int j = 0; j < CH; j++) c[i] += int'(d[j*CN+i]);
            if (c[i] > mx) mx = c[i];
        end
        cls = '0;
        for (int i = 0; i < CN; i++) begin
            if (c[i] == mx) eq++;
            if (!found && c[i] == mx) begin cls = IW'(i); found = 1'b1; end
        end
        cnt  = CW'(mx);
        none = (mx == 0);
        tie  = (mx > 0) && (eq > 1);
    endtask

    task automatic drive(input bit c, input bit v, input logic [DW-1:0] d,
                         input logic [UW-1:0] u, input bit l);
        @(negedge clk);
        cke = c; in_valid = v; in_data = d; in_user = u; in_last = l;
        if (c && !reset) drv_edges++;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [UW-1:0] u, input bit l, input bit rnd,
                        input logic [IW-1:0] ecls, input logic [CW-1:0] ecnt,
                        input bit etie, input bit enone);
        bit   c;
        exp_t e;
        do begin
            c = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            drive(c, 1'b1, d, u, l);
        end while (!c);
        e.cls = ecls; e.cnt = ecnt; e.tie = etie; e.none = enone;
        e.user = u; e.last = l; e.tag = drv_edges;
        sb.push_back(e);
        if (!exp_done) begin
            exp_total++;
            if (!enone && ecls == u[IW-1:0]) exp_ok++;
            if (l) exp_done = 1'b1;
        end
    endtask

    task automatic send_rand(input bit l);
        logic [DW-1:0] d = '0;
        logic [IW-1:0] cls;
        logic [CW-1:0] cnt;
        logic          tie, none;
        logic [UW-1:0] u;
        if ($urandom_range(0, 9) != 0)
            for (int i = 0; i < CN; i++) d |= votes(i, $urandom_range(0, CH));
        model(d, cls, cnt, tie, none);
        u = {4'($urandom_range(0, 15)), ($urandom_range(0, 1) != 0) ? cls : IW'($urandom_range(0, 9))};
        send(d, u, l, 1'b1, cls, cnt, tie, none);
    endtask

    task automatic chk_stats(input string tag);
        check({tag, "_stat_total"}, 128'(stat_total), 128'(ST ? exp_total : 0));
        check({tag, "_stat_ok"},    128'(stat_ok),    128'(ST ? exp_ok : 0));
        check({tag, "_stat_done"},  128'(stat_done),  128'(ST ? exp_done : 1'b0));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 128'({out_valid, out_last, out_class, out_count, out_tie, out_none,
                                    out_user, stat_total, stat_ok, stat_done}), 128'(0));
        @(negedge clk);
        reset = 1'b0;
        idle(2);

        // single samples with drained pipeline between them
        send(votes(3, 7) | votes(5, 2), 8'h03, 1'b0, 1'b0, 4'd3, 3'd7, 1'b0, 1'b0);
        idle(4); chk_stats("clear_win");
        send(votes(2, 4) | votes(8, 4), 8'h08, 1'b0, 1'b0, 4'd2, 3'd4, 1'b1, 1'b0);
        idle(4); chk_stats("tie_low");
        send('0, 8'h00, 1'b0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b1);
        idle(4); chk_stats("all_zero");

        // back-to-back boundary cases
        send('1, 8'hA0, 1'b0, 1'b0, 4'd0, 3'd7, 1'b1, 1'b0);
        send(votes(9, 7) | votes(4, 6), 8'h59, 1'b0, 1'b0, 4'd9, 3'd7, 1'b0, 1'b0);
        send(votes(7, 3) | votes(1, 3) | votes(0, 2), 8'hF7, 1'b0, 1'b0, 4'd1, 3'd3, 1'b1, 1'b0);
        begin
            logic [DW-1:0] d = '0;
            for (int i = 0; i < CN; i++) d |= votes(i, 1);
            send(d, 8'h00, 1'b0, 1'b0, 4'd0, 3'd1, 1'b1, 1'b0);
        end
        idle(4); chk_stats("b2b");

        // reset while one sample sits in stage 1 and another is on the inputs, with cke low
        send(votes(6, 5), 8'h06, 1'b0, 1'b0, 4'd6, 3'd5, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1; cke = 1'b0; in_valid = 1'b1; in_data = votes(4, 3); in_user = 8'h04;
        sb.delete();
        exp_total = 0; exp_ok = 0; exp_done = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        idle(4);
        check("flush_out_valid", 128'(out_valid), 128'(1'b0));
        chk_stats("flush");

        // pseudo-random stream with cke stalls, last flagged on the final sample
        for (int k = 0; k < 100; k++) send_rand(k == 99);
        idle(4); chk_stats("stream");
        for (int k = 0; k < 5; k++) send_rand(1'b0);
        idle(4); chk_stats("frozen");

        check("drain", 128'(sb.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mnist_class_vote_argmax.md
MNIST_CLASS_VOTE_ARGMAX -- requirements
Module: mnist_class_vote_argmax

Interface
REQ-001 Parameter USER_WIDTH, default 8: width of the sideband user field; the low INDEX_WIDTH bits carry the ground-truth label.
REQ-002 Parameter CLASS_NUM, default 10: number of output classes.
REQ-003 Parameter CHANNEL_NUM, default 7: number of spatially multiplexed vote bits per class.
REQ-004 Parameter COUNT_WIDTH, default 3: vote-count width, which shall be at least ceil(log2(CHANNEL_NUM+1)).
REQ-005 Parameter INDEX_WIDTH, default 4: class-index width, which shall be at least ceil(log2(CLASS_NUM)).
REQ-006 clk  input  1  clock; all logic on the rising edge.
REQ-007 reset  input  1  reset, synchronous, active-high.
REQ-008 cke  input  1  clock enable; when it is low, all state holds.
REQ-009 in_data  input  CLASS_NUM*CHANNEL_NUM  vote bits; the bit for channel j of class i is at index j*CLASS_NUM+i.
REQ-010 in_user  input  USER_WIDTH  sideband data, passed through to out_user.
REQ-011 in_last  input  1  marks the final sample of the data set.
REQ-012 in_valid  input  1  qualifies in_data, in_user and in_last.
REQ-013 out_class  output  INDEX_WIDTH  winning class index.
REQ-014 out_count  output  COUNT_WIDTH  vote count of the winning class.
REQ-015 out_tie  output  1  asserted when at least one other class has a vote count equal to the winning count.
REQ-016 out_none  output  1  asserted when every class has zero votes.
REQ-017 out_user, out_last, out_valid  output  USER_WIDTH, 1, 1  sideband data, last flag and valid, each delayed to align with out_class.
REQ-018 stat_total, stat_ok  output  32 each  count of evaluated samples and count of correct samples.
REQ-019 stat_done  output  1  indicates that the sample carrying in_last has been counted.

Function
REQ-020 The block shall have a fixed latency of 2 cke-qualified cycles from in_valid to out_valid and shall accept a new sample on every cycle; there is no backpressure.
REQ-021 Stage 1 shall register, for each class i, the popcount of in_data[j*CLASS_NUM+i] over j=0..CHANNEL_NUM-1, together with the stage-1 copies of user, last and valid.
REQ-022 Stage 2 shall register the argmax of the stage-1 counts, the corresponding max count, the tie flag, the none flag and the sideband signals.
REQ-023 Ties shall resolve to the lowest class index.
REQ-024 When all counts are zero, stage 2 shall output out_none=1, out_class=0, out_count=0 and out_tie=0.
REQ-025 When cke=0, every pipeline register, including the valid bits, shall hold its value; out_valid shall therefore be able to remain high for several cycles while representing a single sample.
REQ-026 Data registers shall load every cke cycle regardless of valid, but their outputs shall only be meaningful while out_valid=1.
REQ-027 A sample shall be correct when out_valid=1, out_none=0 and out_class equals out_user[INDEX_WIDTH-1:0].
REQ-028 On each cke cycle with out_valid=1 and stat_done=0, stat_total shall increment by 1, and stat_ok shall increment by 1 if the sample is correct.
REQ-029 The statistics counters shall saturate at 32'hFFFFFFFF.
REQ-030 When a sample with out_last=1 is counted, stat_done shall set to 1 in the same cycle.
REQ-031 Once stat_done=1, both statistics counters shall freeze until reset; later valid samples shall still appear on the outputs.

Reset
REQ-032 While reset=1 on a clock edge, regardless of cke, all valid registers and all outputs shall be cleared to 0: out_valid, out_last, out_class, out_count, out_tie, out_none, out_user, stat_total, stat_ok and stat_done.
REQ-033 A reset asserted mid-stream shall discard any samples in flight; no out_valid shall appear for samples accepted before the reset edge.
REQ-034 The first valid output after reset deassertion shall appear 2 cke cycles after the first in_valid.

Configuration
REQ-035 When macro MNIST_CLASS_VOTE_STATS_EN is defined, the statistics logic of REQ-027 to REQ-031 shall be compiled in.
REQ-036 When MNIST_CLASS_VOTE_STATS_EN is undefined, the stat_total, stat_ok and stat_done ports shall remain present but be tied to constant 0, and no statistics registers shall be inferred; the pipeline behaviour shall be identical in both builds.

Verification
REQ-037 With CHANNEL_NUM=7 defaults, drive class 3 with 7 votes, class 5 with 2 votes and in_user=3 -> two cycles later expect out_class=3, out_count=7, out_tie=0, out_none=0, out_user=3, and stat_ok incremented by 1.
REQ-038 Drive class 2 and class 8 with 4 votes each and in_user=8 -> expect out_class=2, out_tie=1, and stat_total incremented but stat_ok unchanged.
REQ-039 Drive in_data all zero with in_user=0 -> expect out_none=1, out_class=0, and the sample not counted as correct.
REQ-040 Stream 100 back-to-back samples with cke toggling pseudo-randomly and the last sample flagged -> expect 100 outputs in order, each at 2 cke-cycle latency, stat_total=100, stat_done=1, and counters held on any further input.
REQ-041 Assert reset for 1 cycle while 2 samples are in flight -> expect no out_valid from those samples and all stat outputs equal to 0.
REQ-042 Build without MNIST_CLASS_VOTE_STATS_EN and rerun REQ-037 -> expect identical out_* values and stat_total = stat_ok = stat_done = 0.
